// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command-frame parser:
// parser state encoding, frame delimiter characters and ASCII hex helpers.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ARG_HI = 3'd2,
        ARG_LO = 3'd3,
        CHK_HI = 3'd4,
        CHK_LO = 3'd5,
        END    = 3'd6
    } parser_state_t;

    localparam logic [7:0] CH_SOF = 8'h3C;  // '<'
    localparam logic [7:0] CH_EOF = 8'h3E;  // '>'

    // True for '0'-'9', 'A'-'F' and 'a'-'f'.
    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Nibble value of a hex character; 0 for anything that is not hex.
    function automatic logic [3:0] hex2nib(input logic [7:0] c);
        logic [7:0] t;
        t = 8'h00;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            t = c - 8'h30;
        end else if ((c >= 8'h41) && (c <= 8'h46)) begin
            t = c - 8'h37;
        end else if ((c >= 8'h61) && (c <= 8'h66)) begin
            t = c - 8'h57;
        end
        return t[3:0];
    endfunction

    // Command letters are upper-case only.
    function automatic logic is_cmd_letter(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

endpackage

// File: rtl/uart_hex_dec.sv
// Combinational ASCII hex character decoder: byte -> {valid, nibble}.
// A single instance serves every hex-carrying parser state.
module uart_hex_dec
    import uart_cmd_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       valid,
    output logic [3:0] nibble
);

    // Pure decode, no state.
    assign valid  = is_hex(byte_in);
    assign nibble = hex2nib(byte_in);

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser.
// Decodes '<' CMD HH '>' frames from the UART receive byte stream into
// one-cycle command strobes, and flags malformed, resynchronised or
// timed-out frames with a one-cycle frame_err strobe.
// Optional build macro UART_CMD_CHECKSUM_EN: frames become '<' CMD HH CC '>'
// where CC is the hex of (CMD ^ arg); a checksum mismatch raises frame_err.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err,
    output logic       busy
);

    // Counter value at which a stalled frame is abandoned.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    parser_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_sh_q, cmd_sh_d;
    logic [7:0]       arg_sh_q, arg_sh_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       cmd_code_q, cmd_code_d;
    logic [7:0]       cmd_arg_q, cmd_arg_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       chk_sh_q, chk_sh_d;
`endif

    logic             hex_ok;
    logic [3:0]       hex_nib;

    uart_hex_dec u_hex_dec (
        .byte_in (rx_data),
        .valid   (hex_ok),
        .nibble  (hex_nib)
    );

    // Next-state, shadow capture, timeout and strobe generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_sh_d    = cmd_sh_q;
        arg_sh_d    = arg_sh_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
`ifdef UART_CMD_CHECKSUM_EN
        chk_sh_d    = chk_sh_q;
`endif

        if (rx_done) begin
            // Any received byte restarts the inter-byte timer, even when it
            // arrives in the very cycle the timer would have expired.
            cnt_d = '0;
            if ((state_q != IDLE) && (rx_data == CH_SOF)) begin
                // A new start-of-frame mid-frame aborts the old one and
                // begins the new one immediately.
                frame_err_d = 1'b1;
                state_d     = CMD;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == CH_SOF) begin
                            state_d = CMD;
                        end
                    end
                    CMD: begin
                        if (is_cmd_letter(rx_data)) begin
                            cmd_sh_d = rx_data;
                            state_d  = ARG_HI;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    ARG_HI: begin
                        if (hex_ok) begin
                            arg_sh_d = {arg_sh_q[3:0], hex_nib};
                            state_d  = ARG_LO;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    ARG_LO: begin
                        if (hex_ok) begin
                            arg_sh_d = {arg_sh_q[3:0], hex_nib};
`ifdef UART_CMD_CHECKSUM_EN
                            state_d  = CHK_HI;
`else
                            state_d  = END;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    CHK_HI: begin
                        if (hex_ok) begin
                            chk_sh_d = {chk_sh_q[3:0], hex_nib};
                            state_d  = CHK_LO;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    CHK_LO: begin
                        if (hex_ok) begin
                            chk_sh_d = {chk_sh_q[3:0], hex_nib};
                            state_d  = END;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
`endif
                    END: begin
                        state_d = IDLE;
`ifdef UART_CMD_CHECKSUM_EN
                        if ((rx_data == CH_EOF) && ((cmd_sh_q ^ arg_sh_q) == chk_sh_q)) begin
`else
                        if (rx_data == CH_EOF) begin
`endif
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = cmd_sh_q;
                            cmd_arg_d   = arg_sh_q;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, shadow and output registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_sh_q    <= 8'h00;
            arg_sh_q    <= 8'h00;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_code_q  <= 8'h00;
            cmd_arg_q   <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            chk_sh_q    <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_sh_q    <= cmd_sh_d;
            arg_sh_q    <= arg_sh_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
`ifdef UART_CMD_CHECKSUM_EN
            chk_sh_q    <= chk_sh_d;
`endif
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_arg   = cmd_arg_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Table-driven bench for uart_cmd_parser (TIMEOUT_CYC=16).
// Each table row is one clock cycle: inputs driven on the falling edge, the
// registered outputs compared on the next falling edge. Frame helpers add the
// checksum bytes automatically when UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_parser;

    localparam int TO_CYC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_cmd_parser #(
        .TIMEOUT_CYC (TO_CYC),
        .CNT_W       (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_arg   (cmd_arg),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       done;
        logic [7:0] data;
        logic       ev;
        logic       ee;
        logic       eb;
        logic [7:0] ec;
        logic [7:0] ea;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] cur_code = 8'h00;
    logic [7:0] cur_arg  = 8'h00;

    function automatic logic [7:0] hexch(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};
    endfunction

    task automatic push(input string tag, input logic done, input logic [7:0] data,
                        input logic ev, input logic ee, input logic eb);
        vec_t v;
        v.tag = tag; v.done = done; v.data = data;
        v.ev = ev; v.ee = ee; v.eb = eb; v.ec = cur_code; v.ea = cur_arg;
        vecs.push_back(v);
    endtask

    task automatic idle(input string tag, input int n, input logic eb);
        for (int i = 0; i < n; i++) push(tag, 1'b0, 8'h00, 1'b0, 1'b0, eb);
    endtask

    // Optional checksum bytes, then '>' that completes a good frame.
    task automatic push_tail(input string tag, input logic [7:0] cmd, input logic [7:0] arg,
                             input int gap);
`ifdef UART_CMD_CHECKSUM_EN
        logic [7:0] chk;
        chk = cmd ^ arg;
        push(tag, 1'b1, hexch(chk[7:4]), 1'b0, 1'b0, 1'b1); idle(tag, gap, 1'b1);
        push(tag, 1'b1, hexch(chk[3:0]), 1'b0, 1'b0, 1'b1); idle(tag, gap, 1'b1);
`endif
        cur_code = cmd;
        cur_arg  = arg;
        push(tag, 1'b1, 8'h3E, 1'b1, 1'b0, 1'b0);
        idle(tag, 1, 1'b0);
    endtask

    task automatic push_frame(input string tag, input logic [7:0] cmd, input logic [7:0] hi_ch,
                              input logic [7:0] lo_ch, input logic [7:0] arg, input int gap,
                              input logic first_err);
        push(tag, 1'b1, 8'h3C, 1'b0, first_err, 1'b1); idle(tag, gap, 1'b1);
        push(tag, 1'b1, cmd,   1'b0, 1'b0, 1'b1);      idle(tag, gap, 1'b1);
        push(tag, 1'b1, hi_ch, 1'b0, 1'b0, 1'b1);      idle(tag, gap, 1'b1);
        push(tag, 1'b1, lo_ch, 1'b0, 1'b0, 1'b1);      idle(tag, gap, 1'b1);
        push_tail(tag, cmd, arg, gap);
    endtask

    task automatic check(input string tag, input int idx, input logic [26:0] got,
                         input logic [26:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got v=%b e=%b busy=%b code=%h arg=%h required v=%b e=%b busy=%b code=%h arg=%h",
                     tag, idx, got[26], got[25], got[24], got[23:16], got[15:8],
                     exp[26], exp[25], exp[24], exp[23:16], exp[15:8]);
        end
    endtask

    function automatic logic [26:0] outs();
        return {cmd_valid, frame_err, busy, cmd_code, cmd_arg, 8'h00};
    endfunction

    task automatic step(input string tag, input int idx, input logic done, input logic [7:0] data,
                        input logic [26:0] exp);
        rx_done = done;
        rx_data = data;
        @(negedge clk);
        check(tag, idx, outs(), exp);
        $display("[TB] %s[%0d] done=%b data=%h -> v=%b e=%b busy=%b code=%h arg=%h",
                 tag, idx, done, data, cmd_valid, frame_err, busy, cmd_code, cmd_arg);
    endtask

    initial begin
        // Test 1: spaced frame "<S1F>".
        push_frame("t1", "S", "1", "F", 8'h1F, 3, 1'b0);
        // Test 2: lowercase command rejected, rest ignored in IDLE; then "<B0a>".
        push("t2", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        push("t2", 1'b1, "b",   1'b0, 1'b1, 1'b0);
        push("t2", 1'b1, "0",   1'b0, 1'b0, 1'b0);
        push("t2", 1'b1, "a",   1'b0, 1'b0, 1'b0);
        push("t2", 1'b1, 8'h3E, 1'b0, 1'b0, 1'b0);
        push_frame("t2b", "B", "0", "a", 8'h0A, 0, 1'b0);
        // Test 3: resync "<S1<R22>".
        push("t3", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        push("t3", 1'b1, "S",   1'b0, 1'b0, 1'b1);
        push("t3", 1'b1, "1",   1'b0, 1'b0, 1'b1);
        push_frame("t3", "R", "2", "2", 8'h22, 0, 1'b1);
        // Test 4: "<S1" then silence -> timeout on the 16th idle cycle only.
        push("t4", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        push("t4", 1'b1, "S",   1'b0, 1'b0, 1'b1);
        push("t4", 1'b1, "1",   1'b0, 1'b0, 1'b1);
        idle("t4", TO_CYC - 1, 1'b1);
        push("t4", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle("t4", 3, 1'b0);
        push_frame("t4b", "A", "0", "0", 8'h00, 0, 1'b0);
        // Byte arriving in the expiry cycle wins: no error, frame completes.
        push("t4c", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        push("t4c", 1'b1, "S",   1'b0, 1'b0, 1'b1);
        push("t4c", 1'b1, "1",   1'b0, 1'b0, 1'b1);
        idle("t4c", TO_CYC - 1, 1'b1);
        push("t4c", 1'b1, "F",   1'b0, 1'b0, 1'b1);
        push_tail("t4c", "S", 8'h1F, 0);
        // Test 5: back-to-back bytes "<ZFF>".
        push_frame("t5", "Z", "F", "F", 8'hFF, 0, 1'b0);
        // Bad terminator / bad checksum-high character.
        push("bad_end", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        push("bad_end", 1'b1, "A",   1'b0, 1'b0, 1'b1);
        push("bad_end", 1'b1, "0",   1'b0, 1'b0, 1'b1);
        push("bad_end", 1'b1, "0",   1'b0, 1'b0, 1'b1);
        push("bad_end", 1'b1, "X",   1'b0, 1'b1, 1'b0);
        // Non-hex argument character.
        push("bad_hex", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        push("bad_hex", 1'b1, "A",   1'b0, 1'b0, 1'b1);
        push("bad_hex", 1'b1, "G",   1'b0, 1'b1, 1'b0);
`ifdef UART_CMD_CHECKSUM_EN
        // Test 6: "<S1F4D>" checksum mismatch -> frame_err only.
        push("t6", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        push("t6", 1'b1, "S",   1'b0, 1'b0, 1'b1);
        push("t6", 1'b1, "1",   1'b0, 1'b0, 1'b1);
        push("t6", 1'b1, "F",   1'b0, 1'b0, 1'b1);
        push("t6", 1'b1, "4",   1'b0, 1'b0, 1'b1);
        push("t6", 1'b1, "D",   1'b0, 1'b0, 1'b1);
        push("t6", 1'b1, 8'h3E, 1'b0, 1'b1, 1'b0);
        // "<S1F4C>" matches.
        push_frame("t6b", "S", "1", "F", 8'h1F, 0, 1'b0);
`endif

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset", 0, outs(), 27'h0);
        reset = 1'b0;
        @(negedge clk);
        check("reset", 1, outs(), 27'h0);

        foreach (vecs[i]) begin
            step(vecs[i].tag, i, vecs[i].done, vecs[i].data,
                 {vecs[i].ev, vecs[i].ee, vecs[i].eb, vecs[i].ec, vecs[i].ea, 8'h00});
        end

        // Reset mid-frame: partial frame dropped, outputs cleared, no strobes.
        step("rst_mid", 0, 1'b1, 8'h3C, {3'b001, cur_code, cur_arg, 8'h00});
        step("rst_mid", 1, 1'b1, "Y",   {3'b001, cur_code, cur_arg, 8'h00});
        rx_done = 1'b0;
        reset   = 1'b1;
        #1;
        check("rst_mid", 2, outs(), 27'h0);
        @(negedge clk);
        check("rst_mid", 3, outs(), 27'h0);
        reset = 1'b0;
        step("rst_mid", 4, 1'b1, "F",   27'h0);
        step("rst_mid", 5, 1'b1, "F",   27'h0);
        step("rst_mid", 6, 1'b1, 8'h3E, 27'h0);
        step("rst_mid", 7, 1'b0, 8'h00, 27'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
